// File: rtl/n_pipe_adder_if.sv
// n_pipe_adder_if: operand/result bundle for the pipelined adder.
//
// Parameter: WIDTH - operand and result width in bits.
//
// Signals:
//   in_valid, in_ready       operand-side handshake
//   a, b, c_in, sub          operand beat (sampled only on an input transfer)
//   out_valid, out_ready     result-side handshake
//   sum, c_out, overflow     result beat
//
// Handshake: a beat transfers on a rising clock edge where valid && ready are
// both high. The producer holds valid and its payload until that edge. Ready
// may depend on the consumer's state but never on valid from the same side.
// The result payload is held stable while out_valid && !out_ready.
//
// Modports: master = operand sequencer / result collector side,
//           slave  = the adder itself.
interface n_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/n_pipe_adder.sv
// n_pipe_adder: pipelined add/subtract over STAGES register stages.
//
// Each stage resolves one CHUNK = WIDTH/STAGES bit slice of the result and
// forwards the chunk carry to the next stage. Every beat carries its own sub
// flag, so add and subtract beats may be mixed freely in one stream.
//   sub=0: {c_out,sum} = a + b + c_in
//   sub=1: {c_out,sum} = a + ~b + !c_in  (= a - b - c_in, c_out=1 means no borrow)
// overflow is the signed overflow flag of that addition.
//
// Parameters: WIDTH (multiple of STAGES), STAGES (1..WIDTH).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards every in-flight beat
//   bus    n_pipe_adder_if.slave (operand and result handshakes + payload)
//
// Optional build macro N_ADDER_SAT_EN: when defined, sum saturates to the
// most positive / most negative value on signed overflow (c_out and overflow
// are still the raw values). Without it sum wraps modulo 2^WIDTH.
//
// Latency STAGES cycles, throughput one beat per cycle, full backpressure with
// bubble collapsing. in_ready depends only on out_ready and the valid bits.
module n_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic          clk,
  input logic          rst_n,
  n_pipe_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;
  localparam int LAST  = STAGES - 1;

  // Stage registers. a_q/b_q keep the raw operands so later stages can pick
  // up their chunk; res_q holds the low (k+1)*CHUNK resolved bits of stage k.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] cy_q;
  logic [STAGES-1:0] sub_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];

  // Source of each stage: the input port for stage 0, stage k-1 otherwise.
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_cy;
  logic [STAGES-1:0] src_sub;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_res [STAGES];

  logic [WIDTH-1:0]  nxt_res [STAGES];
  logic [STAGES-1:0] nxt_cy;
  logic [CHUNK:0]    chunk_sum;

  logic [STAGES-1:0] rdy;
  logic              tail_full;

  always_comb begin
    src_v[0]   = bus.in_valid;
    src_a[0]   = bus.a;
    src_b[0]   = bus.b;
    src_sub[0] = bus.sub;
    // Subtraction adds ~b with the inverted borrow-in as the carry-in.
    src_cy[0]  = bus.c_in ^ bus.sub;
    src_res[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]   = v_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_sub[k] = sub_q[k-1];
      src_cy[k]  = cy_q[k-1];
      src_res[k] = res_q[k-1];
    end
  end

  // Chunk adders: stage k resolves bits [k*CHUNK +: CHUNK].
  always_comb begin
    chunk_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      nxt_res[k] = src_res[k];
      chunk_sum  = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, src_b[k][k*CHUNK +: CHUNK] ^ {CHUNK{src_sub[k]}}}
                 + (CHUNK+1)'(src_cy[k]);
      nxt_res[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      nxt_cy[k]  = chunk_sum[CHUNK];
    end
  end

  // ready[k] = !v[k] || ready[k+1], unrolled: stage k can load unless it and
  // every stage after it are occupied and the consumer is stalling.
  always_comb begin
    tail_full = 1'b1;
    rdy       = '0;
    for (int k = 0; k < STAGES; k++) begin
      tail_full = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        tail_full = tail_full & v_q[j];
      end
      rdy[k] = bus.out_ready | ~tail_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      cy_q  <= '0;
      sub_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v_q[k]   <= src_v[k];
          a_q[k]   <= src_a[k];
          b_q[k]   <= src_b[k];
          sub_q[k] <= src_sub[k];
          cy_q[k]  <= nxt_cy[k];
          res_q[k] <= nxt_res[k];
        end
      end
    end
  end

  // Output side is built purely from last-stage registers, so it is stable
  // under backpressure and all-zero straight out of reset.
  logic a_msb;
  logic b_eff_msb;
  logic ovf;

  assign a_msb     = a_q[LAST][MSB];
  assign b_eff_msb = b_q[LAST][MSB] ^ sub_q[LAST];
  assign ovf       = (a_msb == b_eff_msb) && (res_q[LAST][MSB] != a_msb);

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v_q[LAST];
  assign bus.c_out     = cy_q[LAST];
  assign bus.overflow  = ovf;

`ifdef N_ADDER_SAT_EN
  // On overflow both effective operands share a's sign, which is the sign of
  // the true result: 0 -> 0111..1, 1 -> 1000..0.
  assign bus.sum = ovf ? {a_msb, {(WIDTH-1){~a_msb}}} : res_q[LAST];
`else
  assign bus.sum = res_q[LAST];
`endif

endmodule

// File: tb/tb_n_pipe_adder.sv
// tb_n_pipe_adder: self-checking bench for n_pipe_adder.
// Main instance uses the defaults (16 bits, 4 stages); a second 4-bit,
// 2-stage instance covers the small-configuration wrap/overflow case.
module tb_n_pipe_adder;
  localparam int W  = 16;
  localparam int S  = 4;
  localparam int W1 = 4;
  localparam int S1 = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  n_pipe_adder_if #(.WIDTH(W))  bus  ();
  n_pipe_adder_if #(.WIDTH(W1)) bus1 ();

  n_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  n_pipe_adder #(.WIDTH(W1), .STAGES(S1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain integer arithmetic: unsigned result for sum/c_out, signed true
  // result for overflow and saturation. Returns {overflow, c_out, sum}.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sb);
    longint m    = longint'(1) << w;
    longint half = m / 2;
    longint ua   = longint'(a);
    longint ub   = longint'(b);
    longint ci   = cin ? 1 : 0;
    longint full, s, sa, sbv, tr;
    logic   ov, co;
    logic [17:0] r;
    if (!sb) full = ua + ub + ci;
    else     full = ua + m - ub - ci;
    co  = (full >= m);
    s   = full % m;
    sa  = (ua >= half) ? ua - m : ua;
    sbv = (ub >= half) ? ub - m : ub;
    tr  = sb ? (sa - sbv - ci) : (sa + sbv + ci);
    ov  = (tr >= half) || (tr < -half);
`ifdef N_ADDER_SAT_EN
    if (ov) s = (tr > 0) ? half - 1 : half;
`endif
    r = {ov, co, 16'(s)};
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  int          pop_cyc[$];
  logic [17:0] mon_e;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {14'd0, bus.overflow, bus.c_out, bus.sum}, {14'd0, mon_e});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offers one beat and waits (bounded) for its transfer. Returns at
  // posedge+1 after the transfer edge with in_valid still high.
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sb, input bit rnd_ready, output int waited);
    bit acc;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.c_in = cin; bus.sub = sb;
    do begin
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) exp_q.push_back(model(W, a, b, cin, sb));
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < 200);
    if (!acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Called right after a lone beat transferred (out_ready=1, pipe otherwise
  // empty): out_valid must rise exactly S cycles after the beat was offered.
  task automatic latency_check(input string tag, input logic [17:0] expv);
    for (int i = 1; i < S; i++) begin
      @(negedge clk);
      check({tag, "_early"}, {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_value"}, {14'd0, bus.overflow, bus.c_out, bus.sum}, {14'd0, expv});
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    repeat (S + 2) @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int waited;
    int acc_cnt;
    logic [15:0] ra, rb;
    logic rc, rs;
    logic [17:0] t2a, t2b, t6, t1;

`ifdef N_ADDER_SAT_EN
    t1  = {1'b1, 1'b1, 16'h0008};
    t2a = {1'b1, 1'b0, 16'h7FFF};
`else
    t1  = {1'b1, 1'b1, 16'h0007};
    t2a = {1'b1, 1'b0, 16'h8000};
`endif
    t2b = {1'b0, 1'b0, 16'hFFFE};
    t6  = {1'b0, 1'b1, 16'h0000};

    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.c_in = 0; bus.sub = 0; bus.out_ready = 1;
    bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.c_in = 0; bus1.sub = 0; bus1.out_ready = 1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_outputs", {14'd0, bus.overflow, bus.c_out, bus.sum}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Test 1: 4-bit, 2-stage instance
    bus1.in_valid = 1; bus1.a = 4'hF; bus1.b = 4'h8; bus1.c_in = 0; bus1.sub = 0;
    @(negedge clk);
    check("t1_in_ready", {31'd0, bus1.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus1.in_valid = 0;
    @(negedge clk);
    check("t1_early", {31'd0, bus1.out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_valid", {31'd0, bus1.out_valid}, 32'd1);
    check("t1_value", {14'd0, bus1.overflow, bus1.c_out, 12'd0, bus1.sum}, {14'd0, t1});
    check("t1_model", {14'd0, t1}, {14'd0, model(W1, 16'hF, 16'h8, 1'b0, 1'b0)});
    @(posedge clk); #1;

    // Test 2: signed overflow on add, then a subtract with borrow
    push(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, waited); idle();
    latency_check("t2_add", t2a);
    push(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, waited); idle();
    latency_check("t2_sub", t2b);

    // Test 6: carry ripples through every chunk
    push(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, waited); idle();
    latency_check("t6_chain", t6);

    // Test 3: 8 back-to-back beats, no backpressure
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      push(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, waited);
      check("t3_in_ready_held", waited, 32'd1);
    end
    idle();
    drain("t3");
    check("t3_pop_count", pop_cyc.size(), 32'd8);
    if (pop_cyc.size() == 8) check("t3_consecutive", pop_cyc[7] - pop_cyc[0], 32'd7);

    // Test 4: fill with out_ready=0, freeze, then pop+push in one cycle
    bus.out_ready = 1'b0;
    acc_cnt = 0;
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
    bus.in_valid = 1; bus.a = ra; bus.b = rb; bus.c_in = rc; bus.sub = rs;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(W, ra, rb, rc, rs));
        acc_cnt++;
        @(posedge clk); #1;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        bus.a = ra; bus.b = rb; bus.c_in = rc; bus.sub = rs;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("t4_accepted", acc_cnt, S);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      check("t4_out_valid_held", {31'd0, bus.out_valid}, 32'd1);
      if (exp_q.size() != 0)
        check("t4_frozen", {14'd0, bus.overflow, bus.c_out, bus.sum}, {14'd0, exp_q[0]});
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    push(16'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b0, waited);
    check("t4_push_with_pop", waited, 32'd1);
    idle();
    drain("t4");

    // Test 5: asynchronous reset in mid-stream
    for (int i = 0; i < 3; i++)
      push(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, waited);
    idle();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t5_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_sum", {16'd0, bus.sum}, 32'd0);
    check("t5_flags", {30'd0, bus.c_out, bus.overflow}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (S + 2) @(posedge clk);
    #1;
    push(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, waited); idle();
    latency_check("t5_after", model(W, 16'h1234, 16'h4321, 1'b1, 1'b0));

    // Random stream with random gaps and random backpressure
    for (int i = 0; i < 300; i++) begin
      push(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, waited);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        bus.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    idle();
    drain("rand");

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
